seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed 7-segment scan driver for the score/status display.
//  Drives sel[2:0] into the upstream 8:1 nibble mux and takes the selected nibble back
//  on digit_data. Decodes that nibble to segments and drives the digit anodes.
//  Inserts a ghost-blanking gap between digits.
// PARAMETERS
//  CLK_DIV        100000  clk cycles per digit slot; must be >= BLANK_CYC+2
//  BLANK_CYC      16      anode-off cycles at the start of each slot; must be >= 0
//  NUM_DIGITS     8       digits scanned, 1..8; indices NUM_DIGITS-1 down to 0
//  SEG_ACTIVE_LOW 1       1: seg and dp drive low = lit; 0: high = lit
// PORTS
//  clk         in   1  system clock
//  reset_n     in   1  asynchronous active-low reset
//  en          in   1  scan enable; low = display dark, scan parked
//  digit_data  in   4  nibble from the 8:1 mux for the current sel (combinational return)
//  dp_mask     in   8  bit i = decimal point lit on digit i
//  sel         out  3  digit index to the mux (registered)
//  an          out  8  anodes, active-low one-hot; bits >= NUM_DIGITS are always 1
//  seg         out  7  {g,f,e,d,c,b,a} (registered)
//  dp          out  1  decimal point (registered)
//  frame_tick  out  1  1-cycle pulse at the end of each full frame
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - cnt=0, sel=NUM_DIGITS-1, an=8'hFF, seg/dp = unlit, frame_tick=0, state=IDLE.
//  FSM states and transitions:
//   - IDLE: an=8'hFF; cnt=0; sel=NUM_DIGITS-1. Goes to BLANK on the cycle after en=1.
//   - BLANK: cnt runs from 0 to BLANK_CYC; an=8'hFF. When cnt==BLANK_CYC, capture
//     decode(digit_data) into seg and dp_mask[sel] into dp, then go to ON.
//   - ON: cnt runs from BLANK_CYC+1 to CLK_DIV-1; an[sel]=0, all other bits 1.
//     When cnt==CLK_DIV-1: cnt<=0, sel <= (sel==0) ? NUM_DIGITS-1 : sel-1, go to BLANK.
//     frame_tick=1 in that same cycle only when sel==0.
//  Timing:
//   - sel is stable for the whole slot. digit_data settles during BLANK.
//   - seg/dp latency: visible 1 cycle after capture. They hold through the next
//     BLANK phase, which is dark because the anodes are off.
//   - Lit duty per digit = (CLK_DIV-BLANK_CYC-1)/CLK_DIV.
//   - Frame length = NUM_DIGITS*CLK_DIV cycles.
//  Decode:
//   - 0-9: standard digits. A-F: hex glyphs (A,b,C,d,E,F).
//   - Active-high patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F,
//     A=77, b=7C, C=39, d=5E, E=79, F=71.
//   - Inverted when SEG_ACTIVE_LOW=1.
//  en:
//   - en=0 in any state: next cycle state=IDLE, an=8'hFF, cnt and sel reset as above,
//     frame_tick=0, seg/dp hold their values.
//   - Re-enable always restarts at digit NUM_DIGITS-1 with cnt=0.
//  Counter widths: cnt is $clog2(CLK_DIV) bits and never exceeds CLK_DIV-1.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - Internal flag lz is set to 1 at each frame start (sel=NUM_DIGITS-1 entering BLANK).
//   - At capture, if lz=1, digit_data==0 and sel!=0: seg is forced unlit; dp still follows
//     dp_mask.
//   - lz clears at the capture of any nonzero digit or any digit whose dp_mask bit is 1.
//   - Digit 0 is never blanked.
//  LEADING_ZERO_BLANK_EN undefined: all digits are decoded as-is; no lz flag exists.
// TESTING (bench params: CLK_DIV=8, BLANK_CYC=2, NUM_DIGITS=8, SEG_ACTIVE_LOW=1)
//  1. Assert reset_n=0 mid-slot -> same cycle: an=FF, seg=7F, dp=1, sel=7, frame_tick=0.
//  2. en=1, digit_data=sel -> sel steps 7,6,...,0 every 8 cycles; an[sel]=0 only at
//     cnt 3..7; seg=78 while sel=7, seg=40 while sel=0.
//  3. Free run for 3 frames -> frame_tick pulses exactly every 64 cycles, in the last
//     cycle of the digit-0 slot.
//  4. Drop en at cnt=5 of digit 4 -> next cycle an=FF, sel=7. Raise en -> first anode
//     (an=7F) appears 4 cycles after the en rise.
//  5. dp_mask=8'h04 -> dp=0 only while an=8'hFB; dp=1 for every other digit.
//  6. Digits 7..0 = 0,0,0,0,0,1,2,0:
//     - with LEADING_ZERO_BLANK_EN: seg=7F for digits 7..3, 79 (1) on digit 2,
//       24 (2) on digit 1, 40 on digit 0.
//     - without the macro: digits 7..3 show seg=40.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with a ghost-blanking gap at the start of each slot.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
  parameter int unsigned CLK_DIV        = 100000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter int unsigned NUM_DIGITS     = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] digit_data,
  input  logic [7:0] dp_mask,
  output logic [2:0] sel,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned   CntW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntBlankEnd = CntW'(BLANK_CYC);
  localparam logic [CntW-1:0] CntLast     = CntW'(CLK_DIV - 1);
  localparam logic [2:0]    SelFirst    = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]    SegOff      = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic          DpOff       = SEG_ACTIVE_LOW;

  typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [6:0]      seg_lit;
  logic            dp_lit;
`ifdef LEADING_ZERO_BLANK_EN
  logic            lz_q, lz_d;
`endif

  // Active-high {g,f,e,d,c,b,a} glyphs.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  always_comb begin
    seg_lit = SEG_ACTIVE_LOW ? ~decode(digit_data) : decode(digit_data);
    dp_lit  = SEG_ACTIVE_LOW ? ~dp_mask[sel_q] : dp_mask[sel_q];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
`ifdef LEADING_ZERO_BLANK_EN
    lz_d    = lz_q;
`endif
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
      sel_d   = SelFirst;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          cnt_d   = '0;
          sel_d   = SelFirst;
`ifdef LEADING_ZERO_BLANK_EN
          lz_d    = 1'b1;
`endif
        end
        StBlank: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntBlankEnd) begin
            state_d = StOn;
            seg_d   = seg_lit;
            dp_d    = dp_lit;
`ifdef LEADING_ZERO_BLANK_EN
            if (lz_q && (digit_data == 4'h0) && (sel_q != 3'd0)) seg_d = SegOff;
            if ((digit_data != 4'h0) || dp_mask[sel_q]) lz_d = 1'b0;
`endif
          end
        end
        StOn: begin
          if (cnt_q == CntLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            sel_d   = (sel_q == 3'd0) ? SelFirst : sel_q - 3'd1;
`ifdef LEADING_ZERO_BLANK_EN
            if (sel_q == 3'd0) lz_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= SelFirst;
      seg_q   <= SegOff;
      dp_q    <= DpOff;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lz_q <= 1'b1;
    else          lz_q <= lz_d;
  end
`endif

  always_comb begin
    an = 8'hFF;
    if (state_q == StOn) an[sel_q] = 1'b0;
  end

  // A frame dropped by en going low never completes, so no tick.
  assign frame_tick = en && (state_q == StOn) && (cnt_q == CntLast) && (sel_q == 3'd0);
  assign sel        = sel_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (CLK_DIV=8, BLANK_CYC=2, NUM_DIGITS=8).
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       reset_n, en, dp, frame_tick, use_tab;
  logic [3:0] digit_data;
  logic [7:0] dp_mask, an;
  logic [2:0] sel;
  logic [6:0] seg;
  logic [3:0] dig_tab [8];
  int         n_cmp = 0;
  int         n_err = 0;
  int         pos   = 0;

  always #5 clk = ~clk;

  // Upstream nibble mux: either echoes the index or reads a fixed table.
  always_comb digit_data = use_tab ? dig_tab[sel] : {1'b0, sel};

  seg_scan_driver #(
    .CLK_DIV       (8),
    .BLANK_CYC     (2),
    .NUM_DIGITS    (8),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .digit_data(digit_data),
    .dp_mask   (dp_mask),
    .sel       (sel),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_sel(int p);
    return 3'(7 - (p / 8) % 8);
  endfunction

  function automatic logic [7:0] exp_an(int p);
    logic [7:0] m;
    m = 8'hFF;
    if (p % 8 >= 3) m[exp_sel(p)] = 1'b0;
    return m;
  endfunction

  // Active-low glyphs for digit value == index.
  function automatic logic [6:0] seg_id(logic [2:0] s);
    case (s)
      3'd0: return 7'h40;
      3'd1: return 7'h79;
      3'd2: return 7'h24;
      3'd3: return 7'h30;
      3'd4: return 7'h19;
      3'd5: return 7'h12;
      3'd6: return 7'h02;
      default: return 7'h78;
    endcase
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; en = 1'b0; dp_mask = 8'h00; use_tab = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    en = 1'b1;
    repeat (5) tick();
    #3 reset_n = 1'b0;
    #1;
    n_cmp++; if (an !== 8'hFF) begin n_err++; $display("FAIL reset_an got=%h exp=ff", an); end
    n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    n_cmp++; if (dp !== 1'b1) begin n_err++; $display("FAIL reset_dp got=%b exp=1", dp); end
    n_cmp++; if (sel !== 3'd7) begin n_err++; $display("FAIL reset_sel got=%0d exp=7", sel); end
    n_cmp++; if (frame_tick !== 1'b0)
      begin n_err++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
    en = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    n_cmp++; if (an !== 8'hFF) begin n_err++; $display("FAIL idle_an got=%h exp=ff", an); end
  endtask

  task automatic test_scan;
    logic [2:0] s;
    en = 1'b1;
    pos = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      s = exp_sel(pos);
      n_cmp++; if (sel !== s)
        begin n_err++; $display("FAIL scan_sel p=%0d got=%0d exp=%0d", pos, sel, s); end
      n_cmp++; if (an !== exp_an(pos))
        begin n_err++; $display("FAIL scan_an p=%0d got=%h exp=%h", pos, an, exp_an(pos)); end
      if (pos % 8 >= 3) begin
        n_cmp++; if (seg !== seg_id(s))
          begin n_err++; $display("FAIL scan_seg p=%0d got=%h exp=%h", pos, seg, seg_id(s)); end
      end
      pos++;
    end
  endtask

  task automatic test_frame_tick;
    int last;
    int pulses;
    last = 63;
    pulses = 0;
    for (int i = 0; i < 192; i++) begin
      tick();
      if (frame_tick === 1'b1) begin
        pulses++;
        n_cmp++; if (pos - last != 64 || exp_sel(pos) != 3'd0 || pos % 8 != 7)
          begin n_err++; $display("FAIL frame_tick_gap p=%0d got=%0d exp=64", pos, pos - last); end
        last = pos;
      end
      pos++;
    end
    n_cmp++; if (pulses != 3)
      begin n_err++; $display("FAIL frame_tick_count got=%0d exp=3", pulses); end
  endtask

  task automatic test_en_drop;
    for (int i = 0; i < 64 && (pos % 64) != 30; i++) begin
      tick();
      pos++;
    end
    n_cmp++; if (sel !== 3'd4 || an !== 8'hEF)
      begin n_err++; $display("FAIL drop_align got sel=%0d an=%h exp sel=4 an=ef", sel, an); end
    en = 1'b0;
    tick();
    n_cmp++; if (an !== 8'hFF) begin n_err++; $display("FAIL drop_an got=%h exp=ff", an); end
    n_cmp++; if (sel !== 3'd7) begin n_err++; $display("FAIL drop_sel got=%0d exp=7", sel); end
    n_cmp++; if (seg !== 7'h19) begin n_err++; $display("FAIL drop_seg_hold got=%h exp=19", seg); end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++; if (an !== ((i < 4) ? 8'hFF : 8'h7F))
        begin n_err++; $display("FAIL reenable_an cyc=%0d got=%h", i, an); end
    end
    pos = 4;
  endtask

  task automatic test_dp;
    logic exp_dp;
    dp_mask = 8'h04;
    while (pos < 64) begin
      tick();
      pos++;
    end
    for (int i = 0; i < 64; i++) begin
      tick();
      if (pos % 8 >= 3) begin
        exp_dp = (exp_sel(pos) == 3'd2) ? 1'b0 : 1'b1;
        n_cmp++; if (dp !== exp_dp)
          begin n_err++; $display("FAIL dp p=%0d an=%h got=%b exp=%b", pos, an, dp, exp_dp); end
        n_cmp++; if (an !== exp_an(pos))
          begin n_err++; $display("FAIL dp_an p=%0d got=%h exp=%h", pos, an, exp_an(pos)); end
      end
      pos++;
    end
  endtask

  task automatic test_lzb;
    logic [2:0] s;
    logic [6:0] exp_seg;
    dp_mask = 8'h00;
    dig_tab[7] = 4'd0; dig_tab[6] = 4'd0; dig_tab[5] = 4'd0; dig_tab[4] = 4'd0;
    dig_tab[3] = 4'd0; dig_tab[2] = 4'd1; dig_tab[1] = 4'd2; dig_tab[0] = 4'd0;
    use_tab = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      s = exp_sel(pos);
      if (s >= 3'd3) begin
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg = 7'h7F;
`else
        exp_seg = 7'h40;
`endif
      end else if (s == 3'd2) exp_seg = 7'h79;
      else if (s == 3'd1) exp_seg = 7'h24;
      else exp_seg = 7'h40;
      if (pos % 8 >= 3) begin
        n_cmp++; if (seg !== exp_seg)
          begin n_err++; $display("FAIL lzb_seg sel=%0d got=%h exp=%h", s, seg, exp_seg); end
      end
      pos++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_tick();
    test_en_drop();
    test_dp();
    test_lzb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

endmodule
